instr_mem_loader: RTL and testbench

Writer-side counterpart to the CPU's instruction-memory consumer. It clears instruction memory after reset, then accepts a byte stream over a valid/ready handshake, packs bytes into 32-bit instruction words and writes them into instruction memory at consecutive word addresses. When the final byte has been written, it raises `start` to release `SingleCycleCPU`. This lets a program load in hardware instead of through testbench memory initialisation.

---
 rtl/instr_mem_loader.sv | 80 ++++++++
 tb/tb_instr_mem_loader.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: clears instruction memory, then packs a byte stream into words and writes them.
module instr_mem_loader #(
  parameter int DEPTH = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  input  logic              byte_last_i,
  output logic              byte_ready_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [31:0]       wr_data_o,
  output logic              start_o,
  output logic [ADDR_W:0]   word_count_o,
  output logic              overflow_o
);
  typedef enum logic [1:0] {CLEAR, LOAD, DONE} state_t;
  localparam logic [ADDR_W:0] LIMIT = DEPTH[ADDR_W:0];
  state_t state, state_nxt;
  logic [ADDR_W:0] ptr;
  logic [1:0] idx;
  logic [23:0] pack;
  logic take, full, emit;
  logic [31:0] cur, word;
  assign byte_ready_o = state == LOAD;
  always_comb begin
    take = byte_valid_i && state == LOAD;
    full = ptr == LIMIT;
    emit = take && !full && (idx == 2'd3 || byte_last_i);
    cur = {pack, byte_data_i};
    // earlier bytes sit in the low bits of pack, so left-align the partial word to zero-pad it
    word = cur << {2'd3 - idx, 3'b000};
    state_nxt = state == CLEAR ? (full ? LOAD : CLEAR) :
                (take && byte_last_i) ? DONE : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
      ptr <= '0;
      idx <= '0;
      pack <= '0;
      wr_en_o <= 1'b0;
      wr_addr_o <= '0;
      wr_data_o <= '0;
      start_o <= 1'b0;
      word_count_o <= '0;
      overflow_o <= 1'b0;
    end else begin
      state <= state_nxt;
      wr_en_o <= 1'b0;
      if (state == CLEAR) begin
        if (full) ptr <= '0;
        else begin
          wr_en_o <= 1'b1;
          wr_addr_o <= ptr[ADDR_W-1:0];
          wr_data_o <= '0;
          ptr <= ptr + 1'b1;
        end
      end
      if (take && full) overflow_o <= 1'b1;
      if (take && !full) begin
        if (emit) begin
          wr_en_o <= 1'b1;
          wr_addr_o <= ptr[ADDR_W-1:0];
          wr_data_o <= word;
          ptr <= ptr + 1'b1;
          word_count_o <= word_count_o + 1'b1;
          idx <= '0;
          pack <= '0;
        end else begin
          pack <= cur[23:0];
          idx <= idx + 1'b1;
        end
      end
      if (take && byte_last_i) start_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: scoreboard bench; expected writes are queued by stimulus and popped by per-DUT monitors.
module tb_instr_mem_loader;
  logic clk = 0, rst = 1;
  logic valid = 0, last = 0, sel = 0;
  logic [7:0] data = 0;
  logic rdy_a, wr_a, start_a, ovf_a;
  logic [9:0] addr_a;
  logic [31:0] wd_a;
  logic [10:0] wc_a;
  logic rdy_b, wr_b, start_b, ovf_b;
  logic [1:0] addr_b;
  logic [31:0] wd_b;
  logic [2:0] wc_b;
  logic [63:0] qa[$], qb[$];
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  instr_mem_loader #(.DEPTH(1024), .ADDR_W(10)) dut_a (
    .clk(clk), .rst(rst), .byte_valid_i(valid && !sel), .byte_data_i(data),
    .byte_last_i(last), .byte_ready_o(rdy_a), .wr_en_o(wr_a), .wr_addr_o(addr_a),
    .wr_data_o(wd_a), .start_o(start_a), .word_count_o(wc_a), .overflow_o(ovf_a));

  instr_mem_loader #(.DEPTH(4), .ADDR_W(2)) dut_b (
    .clk(clk), .rst(rst), .byte_valid_i(valid && sel), .byte_data_i(data),
    .byte_last_i(last), .byte_ready_o(rdy_b), .wr_en_o(wr_b), .wr_addr_o(addr_b),
    .wr_data_o(wd_b), .start_o(start_b), .word_count_o(wc_b), .overflow_o(ovf_b));

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  always @(negedge clk) if (wr_a) begin
    if (qa.size() == 0) chk("wr_a_unexpected", {32'(addr_a), wd_a}, 64'hx);
    else chk("wr_a", {32'(addr_a), wd_a}, qa.pop_front());
  end

  always @(negedge clk) if (wr_b) begin
    if (qb.size() == 0) chk("wr_b_unexpected", {32'(addr_b), wd_b}, 64'hx);
    else chk("wr_b", {32'(addr_b), wd_b}, qb.pop_front());
  end

  task automatic exp_a(input int a, input logic [31:0] d);
    qa.push_back({32'(a), d});
  endtask

  task automatic do_reset();
    int n;
    valid = 0;
    rst = 1;
    #3;
    chk("rst_ready", rdy_a, 0);
    chk("rst_wr_en", wr_a, 0);
    chk("rst_start", start_a, 0);
    chk("rst_count", wc_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_data", {addr_a, wd_a}, 0);
    repeat (2) @(posedge clk);
    for (int i = 0; i < 1024; i++) exp_a(i, 0);
    for (int i = 0; i < 4; i++) qb.push_back({32'(i), 32'h0});
    @(negedge clk) rst = 0;
    n = 0;
    while (!rdy_a && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
      if (start_a) chk("clear_start", start_a, 0);
    end
    chk("clear_len", n, 1025);
    chk("clear_drained", qa.size(), 0);
  endtask

  task automatic send(input logic [7:0] b, input logic l, input bit gaps);
    int n;
    logic rdy, st;
    if (gaps) for (int g = 0; g < 4 && $urandom_range(1, 0) == 1; g++) begin
      valid = 0;
      @(posedge clk);
      #1;
    end
    valid = 1;
    data = b;
    last = l;
    n = 0;
    rdy = sel ? rdy_b : rdy_a;
    while (!rdy && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      rdy = sel ? rdy_b : rdy_a;
    end
    if (!rdy) chk("ready_timeout", rdy, 1);
    st = sel ? start_b : start_a;
    @(posedge clk);
    #1;
    valid = 0;
    last = 0;
    if (l) begin
      chk("start_before_last", st, 0);
      chk("start_after_last", sel ? start_b : start_a, 1);
    end
  endtask

  logic [7:0] p8[8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] p6[6] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};

  initial begin
    do_reset();
    exp_a(0, 32'h20080005);
    exp_a(1, 32'h00000000);
    for (int i = 0; i < 8; i++) send(p8[i], i == 7, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("p8_count", wc_a, 2);
    chk("p8_ovf", ovf_a, 0);
    chk("done_ready", rdy_a, 0);
    valid = 1;
    repeat (3) @(posedge clk);
    #1;
    valid = 0;
    chk("done_start_held", start_a, 1);
    chk("p8_drained", qa.size(), 0);

    do_reset();
    exp_a(0, 32'hAABBCCDD);
    exp_a(1, 32'h11220000);
    for (int i = 0; i < 6; i++) send(p6[i], i == 5, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("p6_count", wc_a, 2);
    chk("p6_drained", qa.size(), 0);

    do_reset();
    exp_a(0, 32'h20080005);
    exp_a(1, 32'h00000000);
    for (int i = 0; i < 8; i++) send(p8[i], i == 7, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("gap_count", wc_a, 2);
    chk("gap_drained", qa.size(), 0);

    sel = 1;
    for (int i = 0; i < 16; i += 4) qb.push_back({32'(i / 4), 8'(i), 8'(i + 1), 8'(i + 2), 8'(i + 3)});
    for (int i = 0; i < 20; i++) send(8'(i), i == 19, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("ovf_flag", ovf_b, 1);
    chk("ovf_count", wc_b, 4);
    chk("ovf_start", start_b, 1);
    chk("ovf_ready", rdy_b, 0);
    chk("ovf_drained", qb.size(), 0);
    sel = 0;

    do_reset();
    exp_a(0, 32'h20080005);
    exp_a(1, 32'h00000000);
    for (int i = 0; i < 8; i++) send(p8[i], 0, 0);
    send(8'h11, 0, 0);
    send(8'h22, 0, 0);
    #2;
    rst = 1;
    #1;
    chk("midrst_start", start_a, 0);
    chk("midrst_wr_en", wr_a, 0);
    chk("midrst_ready", rdy_a, 0);
    chk("midrst_count", wc_a, 0);
    do_reset();
    exp_a(0, 32'hAABBCCDD);
    exp_a(1, 32'h11220000);
    for (int i = 0; i < 6; i++) send(p6[i], i == 5, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reload_count", wc_a, 2);
    chk("reload_drained_a", qa.size(), 0);
    chk("reload_drained_b", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
